bcd_down_timer: RTL and testbench

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

---
 rtl/bcd_down_timer_pkg.sv | 23 ++
 rtl/bcd_down_timer_if.sv | 25 ++
 rtl/bcd_digit_down.sv | 42 ++++
 rtl/bcd_down_timer.sv | 143 ++++++++++++++
 tb/tb_bcd_down_timer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD down timer: digit geometry, FSM states and
// small BCD helper functions.
package bcd_down_timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

    // Out-of-range digits saturate to the largest legal BCD value.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return bcd_valid(d) ? d : BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle of the BCD down timer; the timer is the slave side.
interface bcd_down_timer_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   preset;
    logic                  start;
    logic                  stop;
    logic                  auto_reload;
    logic [4*DIGITS-1:0]   cnt;
    logic                  tc;
    logic                  done;
    logic                  err;

    modport master (
        output en, load, preset, start, stop, auto_reload,
        input  cnt, tc, done, err
    );

    modport slave (
        input  en, load, preset, start, stop, auto_reload,
        output cnt, tc, done, err
    );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down counter: load has priority over decrement and a
// decrement from 0 wraps to 9.
module bcd_digit_down
    import bcd_down_timer_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             dec,
    input  logic             load,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             is_zero
);

    logic [BCD_W-1:0] q_d;
    logic [BCD_W-1:0] q_q;

    // Next digit value: load, decrement with wrap, or hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
        end else begin
            q_d = q_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign is_zero = (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Cascaded BCD down timer with start/stop/load control, optional auto reload,
// a one-cycle expiry pulse and a sticky invalid-preset flag.
module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    bcd_down_timer_if.slave  bus
);
    import bcd_down_timer_pkg::*;

    localparam int W = BCD_W * DIGITS;

    state_e            state_q;
    state_e            state_d;
    logic [W-1:0]      reload_q;
    logic [W-1:0]      reload_d;
    logic              done_q;
    logic              done_d;
    logic              err_q;
    logic              err_d;

    logic [W-1:0]      preset_clamped_s;
    logic              preset_bad_s;
    logic [W-1:0]      cnt_s;
    logic [W-1:0]      dig_src_s;
    logic [DIGITS-1:0] dig_zero_s;
    logic [DIGITS-1:0] borrow_s;
    logic              dig_load_s;
    logic              dig_dec_s;
    logic              cnt_is_zero_s;
    logic              cnt_is_one_s;

    // Saturate each preset digit and flag any that were out of range.
    always_comb begin
        preset_clamped_s = '0;
        preset_bad_s     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            preset_clamped_s[BCD_W*i +: BCD_W] = bcd_clamp(bus.preset[BCD_W*i +: BCD_W]);
            preset_bad_s = preset_bad_s | ~bcd_valid(bus.preset[BCD_W*i +: BCD_W]);
        end
    end

    assign borrow_s[0] = dig_dec_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk     (clk),
            .clr_n   (clr_n),
            .dec     (borrow_s[g]),
            .load    (dig_load_s),
            .d       (dig_src_s[BCD_W*g +: BCD_W]),
            .q       (cnt_s[BCD_W*g +: BCD_W]),
            .is_zero (dig_zero_s[g])
        );
        // A digit only borrows from the next one up when it is itself at 0.
        if (g < DIGITS - 1) begin : g_borrow
            assign borrow_s[g+1] = borrow_s[g] & dig_zero_s[g];
        end
    end

    assign cnt_is_zero_s = &dig_zero_s;
    assign cnt_is_one_s  = (cnt_s == W'(1));

    // FSM next state, reload register and digit-chain control.
    always_comb begin
        state_d    = state_q;
        reload_d   = reload_q;
        done_d     = 1'b0;
        err_d      = err_q;
        dig_load_s = 1'b0;
        dig_dec_s  = 1'b0;
        dig_src_s  = preset_clamped_s;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.load) begin
            dig_load_s = 1'b1;
            reload_d   = preset_clamped_s;
            err_d      = preset_bad_s;
            case (state_q)
                IDLE:    state_d = bus.start ? RUN : IDLE;
                RUN:     state_d = RUN;
                EXPIRED: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && cnt_is_zero_s) begin
                        done_d  = 1'b1;
                        state_d = EXPIRED;
                    end else if (bus.start) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    // A zero count in RUN (preset of 0 loaded) expires on the next enable.
                    if (!bus.en) begin
                        state_d = RUN;
                    end else if (cnt_is_zero_s) begin
                        done_d  = 1'b1;
                        state_d = EXPIRED;
                    end else if (cnt_is_one_s && bus.auto_reload) begin
                        done_d     = 1'b1;
                        dig_load_s = 1'b1;
                        dig_src_s  = reload_q;
                    end else if (cnt_is_one_s) begin
                        done_d    = 1'b1;
                        dig_dec_s = 1'b1;
                        state_d   = EXPIRED;
                    end else begin
                        dig_dec_s = 1'b1;
                    end
                end
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, reload and status registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.cnt  = cnt_s;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.tc   = (state_q == RUN) & bus.en & cnt_is_one_s;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: a table of directed vectors, a few
// multi-cycle sequences and a randomized run against an integer reference model.
module tb_bcd_down_timer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    logic clk;
    logic clr_n;

    bcd_down_timer_if #(.DIGITS(4)) bus ();

    bcd_down_timer #(.DIGITS(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stp;
        logic        ld;
        logic        st;
        logic        en;
        logic        ar;
        logic [15:0] pre;
        logic [15:0] e_cnt;
        logic        e_done;
        logic        e_err;
        logic        e_tc;
    } vec_t;

    vec_t tbl[$];

    int n_total = 0;
    int n_pass  = 0;

    int m_state;
    int m_cnt;
    int m_reload;
    bit m_err;
    bit m_done;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic int dec_val(input logic [15:0] p);
        int v = 0;
        int m = 1;
        for (int i = 0; i < 4; i++) begin
            int nib = int'(p[4*i +: 4]);
            if (nib > 9) nib = 9;
            v += nib * m;
            m *= 10;
        end
        return v;
    endfunction

    function automatic bit any_bad(input logic [15:0] p);
        bit b = 1'b0;
        for (int i = 0; i < 4; i++) if (p[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int x = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference behaviour of one clock edge, expressed on plain integers.
    task automatic model_step(input bit stp, ld, st, en, ar, input logic [15:0] pre);
        m_done = 1'b0;
        if (stp) begin
            m_state = M_IDLE;
        end else if (ld) begin
            m_cnt    = dec_val(pre);
            m_reload = m_cnt;
            m_err    = any_bad(pre);
            if (m_state == M_EXP) m_state = M_IDLE;
            else if (m_state == M_IDLE && st) m_state = M_RUN;
        end else if (m_state == M_IDLE && st) begin
            if (m_cnt == 0) begin m_done = 1'b1; m_state = M_EXP; end
            else m_state = M_RUN;
        end else if (m_state == M_RUN && en) begin
            if (m_cnt == 0) begin
                m_done = 1'b1; m_state = M_EXP;
            end else if (m_cnt == 1) begin
                m_done = 1'b1;
                if (ar) m_cnt = m_reload;
                else begin m_cnt = 0; m_state = M_EXP; end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic drive(input logic stp, ld, st, en, ar, input logic [15:0] pre);
        bus.stop        = stp;
        bus.load        = ld;
        bus.start       = st;
        bus.en          = en;
        bus.auto_reload = ar;
        bus.preset      = pre;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        m_state = M_IDLE; m_cnt = 0; m_reload = 0; m_err = 1'b0; m_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        tick();
    endtask

    task automatic add(input logic stp, ld, st, en, ar, input logic [15:0] pre,
                       input logic [15:0] ec, input logic ed, ee, et);
        vec_t v;
        v.stp = stp; v.ld = ld; v.st = st; v.en = en; v.ar = ar; v.pre = pre;
        v.e_cnt = ec; v.e_done = ed; v.e_err = ee; v.e_tc = et;
        tbl.push_back(v);
    endtask

    initial begin
        int ndone;
        logic stp, ld, st, en, ar;
        logic [15:0] pre;

        clr_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        #12;
        chk16("reset_cnt", bus.cnt, 16'h0000);
        chk1("reset_done", bus.done, 1'b0);
        chk1("reset_err", bus.err, 1'b0);
        chk1("reset_tc", bus.tc, 1'b0);

        // Directed table: stp ld st en ar preset | cnt done err tc
        add(0,1,0,0,1,16'h0003, 16'h0003,0,0,0);
        add(0,0,1,0,1,16'h0000, 16'h0003,0,0,0);
        add(0,0,0,1,1,16'h0000, 16'h0002,0,0,0);
        add(0,0,0,1,1,16'h0000, 16'h0001,0,0,0);
        add(0,0,0,1,1,16'h0000, 16'h0003,1,0,1);
        add(0,0,0,1,1,16'h0000, 16'h0002,0,0,0);
        add(0,0,0,1,1,16'h0000, 16'h0001,0,0,0);
        add(0,0,0,1,1,16'h0000, 16'h0003,1,0,1);
        add(0,0,0,1,1,16'h0000, 16'h0002,0,0,0);
        add(1,0,0,1,0,16'h0000, 16'h0002,0,0,0);
        add(0,1,0,0,0,16'h0A05, 16'h0905,0,1,0);
        add(0,1,0,0,0,16'h0005, 16'h0005,0,0,0);
        add(1,1,0,0,0,16'h0777, 16'h0005,0,0,0);
        add(0,0,1,1,0,16'h0000, 16'h0005,0,0,0);
        add(0,1,0,1,0,16'h1000, 16'h1000,0,0,0);
        add(0,0,0,1,0,16'h0000, 16'h0999,0,0,0);
        add(1,0,0,0,0,16'h0000, 16'h0999,0,0,0);
        add(0,1,0,0,0,16'h0000, 16'h0000,0,0,0);
        add(0,0,1,0,1,16'h0000, 16'h0000,1,0,0);
        add(0,0,1,1,0,16'h0000, 16'h0000,0,0,0);
        add(0,1,0,0,0,16'h0002, 16'h0002,0,0,0);
        add(0,0,0,1,0,16'h0000, 16'h0002,0,0,0);
        add(0,0,1,1,0,16'h0000, 16'h0002,0,0,0);
        add(0,0,0,1,0,16'h0000, 16'h0001,0,0,0);
        add(0,0,0,1,0,16'h0000, 16'h0000,1,0,1);
        add(0,0,0,1,0,16'h0000, 16'h0000,0,0,0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stp, tbl[i].ld, tbl[i].st, tbl[i].en, tbl[i].ar, tbl[i].pre);
            #1;
            chk1("tbl_tc", bus.tc, tbl[i].e_tc);
            tick();
            chk16("tbl_cnt", bus.cnt, tbl[i].e_cnt);
            chk1("tbl_done", bus.done, tbl[i].e_done);
            chk1("tbl_err", bus.err, tbl[i].e_err);
        end

        // Count 12 down to 0 with en held high.
        do_reset();
        drive(0,1,0,0,0,16'h0012); tick();
        drive(0,0,1,0,0,16'h0000); tick();
        for (int k = 1; k <= 12; k++) begin
            drive(0,0,0,1,0,16'h0000);
            #1;
            chk1("seq12_tc", bus.tc, (k == 12));
            tick();
            chk16("seq12_cnt", bus.cnt, to_bcd(12 - k));
            chk1("seq12_done", bus.done, (k == 12));
        end
        tick();
        chk16("seq12_hold_cnt", bus.cnt, 16'h0000);
        chk1("seq12_hold_done", bus.done, 1'b0);
        drive(0,0,1,0,0,16'h0000); tick();
        chk1("seq12_exp_start", bus.done, 1'b0);

        // Enable gating, stop beating load, reload register kept.
        do_reset();
        drive(0,1,0,0,0,16'h0500); tick();
        drive(0,0,1,0,0,16'h0000); tick();
        drive(0,0,0,1,0,16'h0000); tick();
        chk16("gate_cnt1", bus.cnt, 16'h0499);
        drive(0,0,0,0,0,16'h0000); tick();
        chk16("gate_cnt2", bus.cnt, 16'h0499);
        chk1("gate_done", bus.done, 1'b0);
        drive(0,0,0,1,0,16'h0000); tick();
        chk16("gate_cnt3", bus.cnt, 16'h0498);
        drive(1,1,0,0,0,16'h0123); tick();
        chk16("stopload_cnt", bus.cnt, 16'h0498);
        chk1("stopload_err", bus.err, 1'b0);
        drive(0,0,1,0,1,16'h0000); tick();
        ndone = 0;
        for (int k = 0; k < 497; k++) begin
            drive(0,0,0,1,1,16'h0000); tick();
            if (bus.done) ndone++;
        end
        chk16("rundown_cnt", bus.cnt, 16'h0001);
        chk16("rundown_ndone", 16'(ndone), 16'd0);
        tick();
        chk16("reload_cnt", bus.cnt, 16'h0500);
        chk1("reload_done", bus.done, 1'b1);

        // Asynchronous clear in the middle of a count.
        do_reset();
        drive(0,1,0,0,0,16'h0050); tick();
        drive(0,0,1,0,0,16'h0000); tick();
        for (int k = 0; k < 8; k++) begin
            drive(0,0,0,1,0,16'h0000); tick();
        end
        chk16("mid_cnt", bus.cnt, 16'h0042);
        #3 clr_n = 1'b0;
        #1;
        chk16("aclr_cnt", bus.cnt, 16'h0000);
        chk1("aclr_done", bus.done, 1'b0);
        #2 clr_n = 1'b1;
        tick();
        chk16("aclr_idle_cnt", bus.cnt, 16'h0000);
        chk1("aclr_idle_done", bus.done, 1'b0);
        drive(0,0,1,0,0,16'h0000); tick();
        chk1("aclr_start_done", bus.done, 1'b1);
        chk16("aclr_start_cnt", bus.cnt, 16'h0000);
        drive(0,0,1,0,0,16'h0000); tick();
        chk1("aclr_exp_done", bus.done, 1'b0);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            stp = ($urandom_range(0, 15) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 7) != 0);
            ar  = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       pre = 16'($urandom());
                1:       pre = to_bcd(int'($urandom_range(0, 20)));
                2:       pre = to_bcd(int'($urandom_range(0, 9999)));
                default: pre = to_bcd(int'($urandom_range(1, 3)));
            endcase
            drive(stp, ld, st, en, ar, pre);
            #1;
            chk1("rnd_tc", bus.tc, (m_state == M_RUN) && en && (m_cnt == 1));
            tick();
            model_step(stp, ld, st, en, ar, pre);
            chk16("rnd_cnt", bus.cnt, to_bcd(m_cnt));
            chk1("rnd_done", bus.done, m_done);
            chk1("rnd_err", bus.err, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
